// File: rtl/cache_l1_data_miss_ctrl_pkg.sv
// Shared definitions for the L1 data-cache miss controller.
// Holds the miss FSM states, store-size codes and the default byte-address width.
package cache_l1_data_miss_ctrl_pkg;

    localparam int TAG_SIZE_DEF    = 9;
    localparam int IDX_SIZE_DEF    = 6;
    localparam int WORD_SIZE_DEF   = 2;
    localparam int OFFSET_SIZE_DEF = 2;
    localparam int AW              = TAG_SIZE_DEF + IDX_SIZE_DEF + WORD_SIZE_DEF + OFFSET_SIZE_DEF;
    localparam int CORE_DATA_W     = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FILL  = 3'd4
    } miss_state_t;

    typedef enum logic [2:0] {
        SZ_SB = 3'b000,
        SZ_SH = 3'b001,
        SZ_SW = 3'b010,
        SZ_SD = 3'b011
    } store_size_t;

endpackage

// File: rtl/cache_l1_data_miss_ctrl_if.sv
// Core, L1-fill and L2 signals of the miss controller bundled as one interface.
// slave is the controller's view; master is the surrounding core/L1/L2 view.
interface cache_l1_data_miss_ctrl_if
    import cache_l1_data_miss_ctrl_pkg::*;
#(
    parameter int ADDR_W     = AW,
    parameter int BLOCK_SIZE = 128
) ();

    // core side
    logic                   read_i;
    logic                   write_i;
    logic [2:0]             write_instruction_i;
    logic [ADDR_W-1:0]      addr_i;
    logic [CORE_DATA_W-1:0] data_core_i;
    logic                   hit_i;
    logic                   stall_o;

    // L1 fill side
    logic                   write_L2_o;
    logic [BLOCK_SIZE-1:0]  data_block_o;
    logic [ADDR_W-1:0]      fill_addr_o;
    logic                   write_through_o;

    // L2 side
    logic                   l2_req_o;
    logic                   l2_we_o;
    logic [ADDR_W-1:0]      l2_addr_o;
    logic [1:0]             l2_size_o;
    logic [CORE_DATA_W-1:0] l2_wdata_o;
    logic                   l2_ready_i;
    logic                   l2_rvalid_i;
    logic [BLOCK_SIZE-1:0]  l2_rdata_i;

    modport slave (
        input  read_i, write_i, write_instruction_i, addr_i, data_core_i, hit_i,
        input  l2_ready_i, l2_rvalid_i, l2_rdata_i,
        output stall_o, write_L2_o, data_block_o, fill_addr_o, write_through_o,
        output l2_req_o, l2_we_o, l2_addr_o, l2_size_o, l2_wdata_o
    );

    modport master (
        output read_i, write_i, write_instruction_i, addr_i, data_core_i, hit_i,
        output l2_ready_i, l2_rvalid_i, l2_rdata_i,
        input  stall_o, write_L2_o, data_block_o, fill_addr_o, write_through_o,
        input  l2_req_o, l2_we_o, l2_addr_o, l2_size_o, l2_wdata_o
    );

endinterface

// File: rtl/cache_wt_fifo.sv
// Purpose: generic write-through store buffer, DEPTH (power of 2) entries of WIDTH bits.
// Latency: a push is visible at head the cycle after; head is a direct read of the oldest entry.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/last are registered-state views.
module cache_wt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             last,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign last    = ((wr_ptr - rd_ptr) == (PW+1)'(1));
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/cache_l1_data_miss_ctrl.sv
// Purpose: write-through/no-write-allocate L1 data miss controller with a store buffer drained to L2.
// Latency: load miss with empty buffer = miss cycle, REQ accepted, L2 response delay, one FILL cycle.
// Backpressure: stall_o holds the core during a miss and for stores while busy or the buffer is full.
module cache_l1_data_miss_ctrl
    import cache_l1_data_miss_ctrl_pkg::*;
#(
    parameter int TAG_SIZE    = 9,
    parameter int IDX_SIZE    = 6,
    parameter int WORD_SIZE   = 2,
    parameter int OFFSET_SIZE = 2,
    parameter int BLOCK_SIZE  = 128,
    parameter int WB_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    cache_l1_data_miss_ctrl_if.slave bus
);

    localparam int ADDR_W   = TAG_SIZE + IDX_SIZE + WORD_SIZE + OFFSET_SIZE;
    localparam int LINE_LSB = WORD_SIZE + OFFSET_SIZE;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_LSB){1'b1}}, {LINE_LSB{1'b0}}};

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [1:0]             size;
        logic [CORE_DATA_W-1:0] dat;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    miss_state_t             state_q;
    miss_state_t             state_d;
    logic [ADDR_W-1:0]       miss_addr_q;
    logic [BLOCK_SIZE-1:0]   line_q;

    wb_entry_t               push_entry;
    wb_entry_t               head_entry;
    logic [ENTRY_W-1:0]      head_raw;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_last;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic                    stall;
    logic                    write_through;
    logic                    write_l2;
    logic [BLOCK_SIZE-1:0]   data_block;
    logic [ADDR_W-1:0]       fill_addr;
    logic                    l2_req;
    logic                    l2_we;
    logic [ADDR_W-1:0]       l2_addr;
    logic [1:0]              l2_size;
    logic [CORE_DATA_W-1:0]  l2_wdata;
    logic                    capture_addr;
    logic                    capture_line;
    logic                    unused_size_msb;

    // Only the low two size bits travel to L2; the top bit is a reserved encoding.
    assign unused_size_msb = bus.write_instruction_i[2];

    assign push_entry = '{addr: bus.addr_i, size: bus.write_instruction_i[1:0], dat: bus.data_core_i};
    assign head_entry = wb_entry_t'(head_raw);

    cache_wt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (WB_DEPTH)
    ) u_wb_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .last     (fifo_last),
        .head     (head_raw)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            line_q      <= '0;
        end else begin
            state_q <= state_d;
            if (capture_addr) miss_addr_q <= bus.addr_i;
            if (capture_line) line_q      <= bus.l2_rdata_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        write_through = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        l2_req        = 1'b0;
        l2_we         = 1'b0;
        l2_addr       = '0;
        l2_size       = '0;
        l2_wdata      = '0;
        write_l2      = 1'b0;
        data_block    = '0;
        fill_addr     = '0;
        capture_addr  = 1'b0;
        capture_line  = 1'b0;

        // Reset gates every output to zero even though state still holds its old value this cycle.
        if (!rst_i) begin
            if ((state_q == ST_IDLE || state_q == ST_DRAIN) && !fifo_empty) begin
                l2_req   = 1'b1;
                l2_we    = 1'b1;
                l2_addr  = head_entry.addr;
                l2_size  = head_entry.size;
                l2_wdata = head_entry.dat;
                fifo_pop = bus.l2_ready_i;
            end

            case (state_q)
                ST_IDLE: begin
                    // A store wins over a simultaneous load; the load is simply not seen this cycle.
                    if (bus.write_i) begin
                        if (fifo_full) begin
                            stall = 1'b1;
                        end else begin
                            fifo_push     = 1'b1;
                            write_through = 1'b1;
                        end
                    end else if (bus.read_i && !bus.hit_i) begin
                        stall        = 1'b1;
                        capture_addr = 1'b1;
                        state_d      = fifo_empty ? ST_REQ : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    stall = 1'b1;
                    if (fifo_empty || (fifo_pop && fifo_last)) state_d = ST_REQ;
                end
                ST_REQ: begin
                    stall   = 1'b1;
                    l2_req  = 1'b1;
                    l2_addr = miss_addr_q & LINE_MASK;
                    if (bus.l2_ready_i) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    stall = 1'b1;
                    if (bus.l2_rvalid_i) begin
                        capture_line = 1'b1;
                        state_d      = ST_FILL;
                    end
                end
                ST_FILL: begin
                    stall      = 1'b1;
                    write_l2   = 1'b1;
                    data_block = line_q;
                    fill_addr  = miss_addr_q & LINE_MASK;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.stall_o         = stall;
    assign bus.write_through_o = write_through;
    assign bus.write_L2_o      = write_l2;
    assign bus.data_block_o    = data_block;
    assign bus.fill_addr_o     = fill_addr;
    assign bus.l2_req_o        = l2_req;
    assign bus.l2_we_o         = l2_we;
    assign bus.l2_addr_o       = l2_addr;
    assign bus.l2_size_o       = l2_size;
    assign bus.l2_wdata_o      = l2_wdata;

endmodule

// File: doc/cache_l1_data_miss_ctrl.md
CACHE_L1_DATA_MISS_CTRL -- requirements
Module: cache_l1_data_miss_ctrl

Interface
REQ-001 SHALL have parameters: TAG_SIZE 9, tag bits; IDX_SIZE 6, index bits; WORD_SIZE 2, word-select bits; OFFSET_SIZE 2, byte-offset bits; BLOCK_SIZE 128, line bits; WB_DEPTH 4, write-through buffer entries (power of 2).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk_i in 1, rising-edge clock; rst_i in 1, synchronous active-high reset.
REQ-003 SHALL have core-side ports: read_i in 1, load request; write_i in 1, store request; write_instruction_i in 3, store size (000 SB, 001 SH, 010 SW, 011 SD); addr_i in AW=TAG+IDX+WORD+OFFSET, byte address; data_core_i in 64, store data; hit_i in 1, L1 hit; stall_o out 1, core hold.
REQ-004 SHALL have L1-side ports: write_L2_o out 1, line-fill strobe; data_block_o out BLOCK_SIZE, fill line; fill_addr_o out AW, line-aligned fill address; write_through_o out 1, store being posted.
REQ-005 SHALL have L2-side ports: l2_req_o out 1; l2_we_o out 1; l2_addr_o out AW; l2_size_o out 2; l2_wdata_o out 64; l2_ready_i in 1, request accepted; l2_rvalid_i in 1; l2_rdata_i in BLOCK_SIZE.

Function
REQ-006 SHALL implement a write-through, no-write-allocate policy; every store is enqueued in a WB_DEPTH FIFO of {addr, size, data}.
REQ-007 SHALL enqueue a store in the cycle write_i=1 and the FIFO is not full; write_through_o SHALL be 1 in that cycle.
REQ-008 SHALL assert stall_o combinationally when write_i=1 and the FIFO is full; a simultaneous dequeue SHALL NOT permit the enqueue in that cycle.
REQ-009 SHALL use FSM states IDLE, DRAIN, REQ, WAIT, FILL.
REQ-010 IDLE: read_i=1 and hit_i=0 SHALL move to DRAIN if the FIFO is non-empty, else to REQ; stall_o=1 from that cycle.
REQ-011 In IDLE and DRAIN, the FIFO head SHALL be presented on l2_req_o=1, l2_we_o=1; the entry SHALL pop on l2_req_o & l2_ready_i.
REQ-012 DRAIN SHALL move to REQ in the cycle the last entry pops.
REQ-013 REQ SHALL drive l2_req_o=1, l2_we_o=0, l2_addr_o = latched miss address with the low WORD+OFFSET bits zeroed, holding all of them until l2_ready_i=1, then go to WAIT.
REQ-014 WAIT SHALL capture l2_rdata_i when l2_rvalid_i=1 and go to FILL; l2_rvalid_i outside WAIT SHALL be ignored.
REQ-015 FILL SHALL last exactly one cycle with write_L2_o=1, data_block_o = captured line, and fill_addr_o = the line address; it SHALL then go to IDLE and deassert stall_o in the next cycle.
REQ-016 Minimum miss latency with an empty FIFO SHALL be 3 cycles plus L2 response delay (REQ accepted, response, FILL).
REQ-017 read_i and write_i both high SHALL be treated as a protocol error; the store SHALL take priority.
REQ-018 l2_size_o SHALL equal write_instruction_i[1:0] of the entry. l2_wdata_o SHALL be the 64-bit core data, unshifted.
REQ-019 Stores arriving while in DRAIN, REQ, WAIT, or FILL SHALL be stalled (stall_o=1), not enqueued.

Reset
REQ-020 rst_i=1 SHALL force state IDLE, the FIFO empty (pointers 0), and the captured line 0.
REQ-021 During reset, all outputs SHALL be 0: stall_o, write_L2_o, write_through_o, l2_req_o, l2_we_o, l2_addr_o, l2_size_o, l2_wdata_o, data_block_o, fill_addr_o.
REQ-022 Reset mid-miss SHALL abandon the transaction, and a late l2_rvalid_i SHALL be ignored.

Structure
REQ-023 A shared package SHALL hold the FSM state enumeration, the store-size codes, and the address-width constant AW.
REQ-024 The FIFO SHALL be a sub-module cache_wt_fifo with push, pop, full, empty, and head outputs.

Verification
REQ-025 Load miss, FIFO empty, addr 0x1234A, L2 returns 0xDEADBEEF_0123... after 2 cycles -> l2_addr_o=0x12340; one-cycle write_L2_o with that line; stall_o drops after FILL.
REQ-026 Five SW stores back-to-back with l2_ready_i=0 -> 4 enqueued; the 5th is stalled until l2_ready_i=1 pops one, then enqueues.
REQ-027 Two stores pending, then a load miss -> both are written to L2 in order with l2_we_o=1, then the read request follows; no fill occurs before the drain completes.
REQ-028 rst_i pulsed while in WAIT, then l2_rvalid_i=1 -> no write_L2_o, state IDLE, all outputs 0.
REQ-029 Load hit (hit_i=1) -> no l2_req_o and stall_o=0; SB at 0x00003 -> l2_size_o=00, l2_addr_o=0x00003.
